// File: rtl/wb_uart_pkg.sv
// rtl/wb_uart_pkg.sv - shared register map, status bit positions and receiver FSM encoding
package wb_uart_pkg;

   // Wishbone register addresses
   localparam logic [1:0] ADR_RXDATA = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_CTRL   = 2'd2;
   localparam logic [1:0] ADR_RSVD   = 2'd3;

   // STATUS register bit positions
   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FRAME_ERR = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FULL      = 3;

   // CTRL register bit positions
   localparam int CTRL_IRQ_EN  = 0;

   // Receiver state machine encoding
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - power-of-two receive FIFO with push/pop/full/empty/count
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - 8N1 UART receiver with receive FIFO behind a Wishbone classic slave
module wb_uart_rx
   import wb_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic [1:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   input  logic       wb_we_i,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   output logic       wb_ack_o,
   output logic       irq_o
);

   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("CLKS_PER_BIT must be at least 4");
   end
   if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
   end

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   logic            rx_meta_q, rx_sync_q;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            push, frame_set;

   logic [7:0]      fifo_data;
   logic            fifo_full, fifo_empty, fifo_pop;
   logic [FCW-1:0]  fifo_count;

   logic            frame_err_q, overrun_q, irq_en_q;
   logic            ack_q, pop_q, clr_fe_q, clr_ov_q, ctrl_wr_q, ctrl_val_q;
   logic [7:0]      dat_q, rdata, status_vec;
   logic            req;
   logic            unused_wdat;

   assign unused_wdat = ^wb_dat_i[7:3];

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver state, baud counter, bit index and shift register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic: start is re-checked mid-bit, data and stop sampled at bit centres
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               state_d = S_START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d   = '0;
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_d   = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (fifo_pop),
      .data_i  (shift_q),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
   assign fifo_pop = pop_q;

   // Read mux evaluated at request time and registered into the ack cycle
   always_comb begin
      status_vec               = '0;
      status_vec[ST_NOT_EMPTY] = ~fifo_empty;
      status_vec[ST_FRAME_ERR] = frame_err_q;
      status_vec[ST_OVERRUN]   = overrun_q;
      status_vec[ST_FULL]      = (fifo_count == FCW'(FIFO_DEPTH));
      rdata = '0;
      case (wb_adr_i)
         ADR_RXDATA: rdata = fifo_empty ? 8'h00 : fifo_data;
         ADR_STATUS: rdata = status_vec;
         ADR_CTRL:   rdata = {7'd0, irq_en_q};
         default:    rdata = '0;
      endcase
   end

   // Bus handshake; decoded side effects are latched so they fire only during ack
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_q      <= 1'b0;
         pop_q      <= 1'b0;
         clr_fe_q   <= 1'b0;
         clr_ov_q   <= 1'b0;
         ctrl_wr_q  <= 1'b0;
         ctrl_val_q <= 1'b0;
         dat_q      <= '0;
      end else begin
         ack_q      <= req;
         pop_q      <= req & ~wb_we_i & (wb_adr_i == ADR_RXDATA) & ~fifo_empty;
         clr_fe_q   <= req & wb_we_i & (wb_adr_i == ADR_STATUS) & wb_dat_i[ST_FRAME_ERR];
         clr_ov_q   <= req & wb_we_i & (wb_adr_i == ADR_STATUS) & wb_dat_i[ST_OVERRUN];
         ctrl_wr_q  <= req & wb_we_i & (wb_adr_i == ADR_CTRL);
         ctrl_val_q <= wb_dat_i[CTRL_IRQ_EN];
         dat_q      <= (req & ~wb_we_i) ? rdata : 8'h00;
      end
   end

   // Sticky error flags and interrupt enable; a new error beats a same-cycle clear
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         irq_en_q    <= 1'b0;
      end else begin
         if (frame_set)                             frame_err_q <= 1'b1;
         else if (clr_fe_q)                         frame_err_q <= 1'b0;
         if (push & fifo_full & ~fifo_pop)          overrun_q   <= 1'b1;
         else if (clr_ov_q)                         overrun_q   <= 1'b0;
         if (ctrl_wr_q)                             irq_en_q    <= ctrl_val_q;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign irq_o    = irq_en_q & (~fifo_empty | frame_err_q | overrun_q);

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - scoreboard bench for wb_uart_rx with a queue-based reference model
module tb_wb_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] adr = '0;
   logic [7:0] wdat = '0;
   logic       we = 1'b0, stb = 1'b0, cyc = 1'b0;
   logic [7:0] rdat;
   logic       ack, irq;

   int checks = 0;
   int errors = 0;

   // scoreboard of expected read data; -1 marks a write ack (nothing to compare)
   int sb_q[$];

   // reference model: FIFO contents, sticky flags, interrupt enable
   logic [7:0] m_fifo[$];
   bit m_fe = 0, m_ov = 0, m_ien = 0;

   wb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .rx_i     (rx),
      .wb_adr_i (adr),
      .wb_dat_i (wdat),
      .wb_dat_o (rdat),
      .wb_we_i  (we),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_ack_o (ack),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // monitor: every ack pops one expectation
   always @(negedge clk) begin
      int e;
      if (ack) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack with data %02h, required no ack", rdat);
         end else begin
            e = sb_q.pop_front();
            if (e >= 0) begin
               checks++;
               if (rdat !== e[7:0]) begin
                  errors++;
                  $display("FAIL read_data: got %02h required %02h", rdat, e[7:0]);
               end
            end
         end
      end
   end

   function automatic logic [7:0] m_status();
      logic [7:0] s;
      s = 8'h00;
      s[0] = (m_fifo.size() != 0);
      s[1] = m_fe;
      s[2] = m_ov;
      s[3] = (m_fifo.size() == DEPTH);
      return s;
   endfunction

   function automatic logic m_irq();
      return m_ien & ((m_fifo.size() != 0) | m_fe | m_ov);
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h required %02h", name, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d, input int exp);
      bit got;
      sb_q.push_back(exp);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) got = 1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack, required ack within 10 cycles");
         void'(sb_q.pop_back());
      end
   endtask

   task automatic rd_data();
      int e;
      e = (m_fifo.size() != 0) ? int'(m_fifo.pop_front()) : 0;
      wb_xfer(1'b0, 2'd0, 8'h00, e);
   endtask

   task automatic rd_status();
      wb_xfer(1'b0, 2'd1, 8'h00, int'(m_status()));
   endtask

   task automatic wr_status(input logic [7:0] v);
      wb_xfer(1'b1, 2'd1, v, -1);
      if (v[1]) m_fe = 0;
      if (v[2]) m_ov = 0;
   endtask

   task automatic wr_ctrl(input logic [7:0] v);
      wb_xfer(1'b1, 2'd2, v, -1);
      m_ien = v[0];
   endtask

   task automatic hold_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // one complete frame, then let the receiver settle before updating the model
   task automatic send(input logic [7:0] b, input logic stop);
      @(negedge clk);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(b[i]);
      hold_bit(stop);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      if (!stop)                     m_fe = 1;
      else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
      else                           m_ov = 1;
   endtask

   task automatic check_irq(input string name);
      @(posedge clk);
      #1;
      check(name, {7'd0, irq}, {7'd0, m_irq()});
   endtask

   initial begin
      logic [7:0] v;
      int op;

      repeat (4) @(negedge clk);
      #1;
      check("reset_ack", {7'd0, ack}, 8'h00);
      check("reset_dat", rdat, 8'h00);
      check("reset_irq", {7'd0, irq}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_status();

      // single byte
      send(8'hA5, 1'b1);
      rd_status();
      rd_data();
      rd_status();

      // overrun: five bytes into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      rd_status();
      for (int i = 0; i < 5; i++) rd_data();
      rd_status();
      wr_status(8'h04);
      rd_status();

      // framing error then clear
      send(8'h3C, 1'b0);
      rd_status();
      wr_status(8'h02);
      rd_status();

      // short glitch is ignored
      @(negedge clk);
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      rd_status();

      // interrupt path and register readback
      wr_ctrl(8'h01);
      wb_xfer(1'b0, 2'd2, 8'h00, {31'd0, m_ien});
      wb_xfer(1'b1, 2'd3, 8'hFF, -1);
      wb_xfer(1'b0, 2'd3, 8'h00, 0);
      check_irq("irq_idle");
      send(8'h7E, 1'b1);
      check_irq("irq_after_rx");
      rd_data();
      check_irq("irq_after_pop");

      // reset during the data bits of 0x55
      @(negedge clk);
      hold_bit(1'b0);
      hold_bit(1'b1);
      hold_bit(1'b0);
      rx = 1'b1;
      rst_n = 1'b0;
      #1;
      check("midreset_ack", {7'd0, ack}, 8'h00);
      check("midreset_dat", rdat, 8'h00);
      check("midreset_irq", {7'd0, irq}, 8'h00);
      m_fifo.delete();
      m_fe = 0; m_ov = 0; m_ien = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_status();
      send(8'h99, 1'b1);
      rd_data();
      rd_status();

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 6);
         v  = 8'($urandom);
         case (op)
            0, 1: send(v, ($urandom_range(0, 9) != 0));
            2:    rd_data();
            3:    rd_status();
            4:    wr_status(v);
            5:    wr_ctrl(v);
            default: wb_xfer(1'b0, 2'd2, 8'h00, {31'd0, m_ien});
         endcase
         check_irq("irq_random");
      end
      while (m_fifo.size() != 0) rd_data();
      rd_status();

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_uart_rx.md
WB_UART_RX -- requirements
Module: wb_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk_i cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 rx_i  input  1  UART serial in, 8N1, idle high, asynchronous to clk_i.
REQ-007 wb_adr_i  input  2  register select.
REQ-008 wb_dat_i  input  8  write data.
REQ-009 wb_dat_o  output  8  read data.
REQ-010 wb_we_i, wb_stb_i, wb_cyc_i  input  1 each  Wishbone classic slave controls.
REQ-011 wb_ack_o  output  1  single-cycle acknowledge.
REQ-012 irq_o  output  1  level interrupt: irq_en & (not_empty | frame_err | overrun).

Function
REQ-013 rx_i SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE -> START on synchronized rx low; bit counter reloaded.
REQ-016 START: after CLKS_PER_BIT/2 cycles, rx low -> DATA; rx high -> IDLE (glitch, nothing recorded).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first into shift register, then -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte, -> IDLE; 0 -> set frame_err, discard byte, -> WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE on first synchronized rx high cycle.
REQ-020 Pushed byte SHALL be visible (not_empty=1) the cycle after stop-bit sample.
REQ-021 Push while full and no pop: byte dropped, overrun set, FIFO unchanged.
REQ-022 Push and pop in same cycle while full: both take effect, count unchanged, no overrun.
REQ-023 Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-024 Register map: 0 RXDATA (R, read pops head); 1 STATUS (R: bit0 not_empty, bit1 frame_err, bit2 overrun, bit3 full, bits7:4 zero; W: bits1/2 write-1-to-clear); 2 CTRL (R/W bit0 irq_en, others read zero); 3 reads 0x00, writes ignored.
REQ-025 RXDATA read when empty SHALL return 0x00 with no pointer change.
REQ-026 wb_ack_o SHALL assert the cycle after stb&cyc with ack low, for exactly one cycle; side effects (pop, clear, write) occur in that ack cycle only.
REQ-027 wb_dat_o SHALL be registered, valid during ack, 0x00 otherwise.
REQ-028 Error flag set and W1C clear in same cycle: set wins.

Reset
REQ-029 rst_i low SHALL force: FSM IDLE, FIFO empty, pointers 0, frame_err=0, overrun=0, irq_en=0, wb_ack_o=0, wb_dat_o=0x00, irq_o=0, synchronizer=1.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, reception restarts only on a new falling edge.

Structure
REQ-031 Register addresses, STATUS bit positions, and FSM state encodings SHALL live in shared package wb_uart_pkg.
REQ-032 FIFO SHALL be a sub-module uart_rx_fifo (push, pop, data, full, empty, count).
REQ-033 Parameters SHALL be elaboration-checked: FIFO_DEPTH power of two, CLKS_PER_BIT >= 4.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-034 Send 0xA5 on rx_i -> STATUS=0x01 within 20 cycles of stop bit; RXDATA read=0xA5; STATUS then 0x00.
REQ-035 Send 5 bytes 0x01..0x05 without reads -> STATUS=0x0D (not_empty, overrun, full); reads return 0x01..0x04, then 0x00.
REQ-036 Frame with stop bit 0, data 0x3C -> STATUS bit1=1, FIFO empty; write 0x02 to STATUS -> STATUS=0x00.
REQ-037 Low pulse of 6 cycles on rx_i -> FSM returns to IDLE, STATUS stays 0x00.
REQ-038 CTRL=0x01, send 0x7E -> irq_o high after stop bit; read RXDATA -> irq_o low next cycle.
REQ-039 Assert rst_i low during DATA of 0x55 -> all outputs at reset values; subsequent 0x99 received correctly.
